// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the writeback entry type
// Purpose: constants common to the register file and its write buffer, plus
//          the {reg, data} record held in each write-buffer slot.
// Ports:   none (package).
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-match lookup across write-buffer entries
// Purpose: reports whether any valid buffered entry targets the query register
//          and, if so, the data of the youngest such entry.
// Ports:   entries/valid - buffer slots and their valid bits
//          head          - index of the oldest entry
//          query         - register index being looked up
//          hit/data      - match flag and youngest matching data (0 if no hit)
module fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [ADDR_W-1:0]     query,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PTR_W-1:0] idx;

  // Valid entries are contiguous starting at head, so walking from head
  // outward visits oldest to youngest; the last match seen is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (entries[idx].dst_reg == query)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - in-order writeback FIFO owning the register-file write port
// Purpose: buffers execute-stage results, drains one per cycle into the
//          register file and forwards not-yet-committed values to decode.
// Ports:   clk/rst                        - clock, async active-high reset
//          in_valid/in_ready/in_reg/in_data - result intake handshake
//          drain_hold                      - freezes draining
//          write_reg/write_data/write_enable - register-file write port
//          query_regK/fwd_hitK/fwd_dataK   - two independent bypass lookups
//          count/empty                     - occupancy
module rf_write_buffer #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_hold,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  input  logic [ADDR_W-1:0] query_reg1,
  input  logic [ADDR_W-1:0] query_reg2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [ADDR_W-1:0] count,
  output logic              empty
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push, pop;

  // in_ready looks only at registered occupancy so the producer never sees
  // a combinational loop through its own valid or through drain_hold.
  assign in_ready     = (count_q != FULL);
  assign empty        = (count_q == '0);
  assign push         = in_valid && in_ready;
  assign write_enable = !empty && !drain_hold;
  assign pop          = write_enable;
  assign write_reg    = empty ? '0 : entries_q[head_q].dst_reg;
  assign write_data   = empty ? '0 : entries_q[head_q].data;
  assign count        = ADDR_W'(count_q);

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      entries_d[tail_q].dst_reg = in_reg;
      entries_d[tail_q].data    = in_data;
      valid_d[tail_q]           = 1'b1;
      tail_d                    = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // The entry being committed this cycle still forwards: the register file
  // only shows the new value after the edge.
  fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd1 (
    .entries (entries_q),
    .valid   (valid_q),
    .head    (head_q),
    .query   (query_reg1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd2 (
    .entries (entries_q),
    .valid   (valid_q),
    .head    (head_q),
    .query   (query_reg2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - scoreboard bench for rf_write_buffer
module tb_rf_write_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_hold;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        write_enable;
  logic [3:0]  query_reg1;
  logic [3:0]  query_reg2;
  logic        fwd_hit1;
  logic [15:0] fwd_data1;
  logic        fwd_hit2;
  logic [15:0] fwd_data2;
  logic [3:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  logic [15:0] rf_seen [16];

  rf_write_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg       (in_reg),
    .in_data      (in_data),
    .drain_hold   (drain_hold),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .query_reg1   (query_reg1),
    .query_reg2   (query_reg2),
    .fwd_hit1     (fwd_hit1),
    .fwd_data1    (fwd_data1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data2    (fwd_data2),
    .count        (count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every committed write must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=reg%0d/0x%0h expected=none", write_reg, write_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("write_reg", int'(write_reg), int'(e[19:16]));
        chk("write_data", int'(write_data), int'(e[15:0]));
      end
      rf_seen[write_reg] = write_data;
    end
  end

  // Presents one result for a single edge; exp_acc is the hand-derived
  // expectation of whether the buffer takes it.
  task automatic push(input logic [3:0] r, input logic [15:0] d, input logic exp_acc);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    chk("in_ready_before_push", int'(in_ready), int'(exp_acc));
    if (exp_acc) exp_q.push_back({r, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_reg     = '0;
    in_data    = '0;
    drain_hold = 1'b0;
    query_reg1 = '0;
    query_reg2 = '0;
    for (int i = 0; i < 16; i++) rf_seen[i] = '0;
    cycles(2);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_write_enable", int'(write_enable), 0);
    rst = 1'b0;
    cycles(1);

    // Single push into an empty buffer
    query_reg1 = 4'd5;
    push(4'd5, 16'h1234, 1'b1);
    chk("single_we", int'(write_enable), 1);
    chk("single_wreg", int'(write_reg), 5);
    chk("single_wdata", int'(write_data), 16'h1234);
    chk("single_fwd_hit1", int'(fwd_hit1), 1);
    chk("single_fwd_data1", int'(fwd_data1), 16'h1234);
    cycles(1);
    chk("single_empty_after", int'(empty), 1);

    // Fill with drain held, then backpressure
    drain_hold = 1'b1;
    push(4'd1, 16'h0011, 1'b1);
    push(4'd2, 16'h0022, 1'b1);
    push(4'd3, 16'h0033, 1'b1);
    push(4'd4, 16'h0044, 1'b1);
    chk("fill_count", int'(count), 4);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_we_held", int'(write_enable), 0);
    push(4'd6, 16'h0066, 1'b0);
    chk("fill_count_after_5th", int'(count), 4);
    drain_hold = 1'b0;
    cycles(4);
    chk("fill_drained_empty", int'(empty), 1);

    // Youngest-entry forwarding
    drain_hold = 1'b1;
    query_reg2 = 4'd7;
    push(4'd7, 16'hAAAA, 1'b1);
    push(4'd7, 16'hBBBB, 1'b1);
    chk("young_hit2", int'(fwd_hit2), 1);
    chk("young_data2", int'(fwd_data2), 16'hBBBB);
    drain_hold = 1'b0;
    cycles(3);
    chk("young_rf_r7", int'(rf_seen[7]), 16'hBBBB);

    // Dual independent queries
    drain_hold = 1'b1;
    push(4'd2, 16'h0002, 1'b1);
    push(4'd9, 16'h0009, 1'b1);
    query_reg1 = 4'd2;
    query_reg2 = 4'd3;
    #1;
    chk("dual_hit1", int'(fwd_hit1), 1);
    chk("dual_data1", int'(fwd_data1), 16'h0002);
    chk("dual_hit2", int'(fwd_hit2), 0);
    chk("dual_data2", int'(fwd_data2), 0);
    drain_hold = 1'b0;
    cycles(3);

    // Simultaneous push and pop at count 3, then continuous streaming
    drain_hold = 1'b1;
    push(4'd10, 16'h0A0A, 1'b1);
    push(4'd11, 16'h0B0B, 1'b1);
    push(4'd12, 16'h0C0C, 1'b1);
    chk("pp_count_before", int'(count), 3);
    drain_hold = 1'b0;
    push(4'd13, 16'h0D0D, 1'b1);
    chk("pp_count_after", int'(count), 3);
    for (int i = 0; i < 10; i++) push(4'(i), 16'h0100 + 16'(i), 1'b1);
    chk("stream_count", int'(count), 3);
    cycles(5);
    chk("stream_empty", int'(empty), 1);

    // Asynchronous reset mid-cycle with entries buffered
    drain_hold = 1'b1;
    query_reg1 = 4'd14;
    push(4'd14, 16'hE0E0, 1'b1);
    push(4'd15, 16'hF0F0, 1'b1);
    push(4'd0, 16'h0F0F, 1'b1);
    chk("rst_pre_count", int'(count), 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_async_count", int'(count), 0);
    chk("rst_async_we", int'(write_enable), 0);
    chk("rst_async_hit1", int'(fwd_hit1), 0);
    chk("rst_async_empty", int'(empty), 1);
    drain_hold = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(4);
    chk("rst_no_leftover", int'(empty), 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
